// File: rtl/pipe_stage_pkg.sv
// Shared definitions for the pipe_stage register slice: occupancy-coded state
// encoding and the default PC reported while the stage is in reset.
package pipe_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_entry_reg.sv
// One payload slot of the stage (pc, control, data, destination register),
// loaded on enable and asynchronously cleared to its reset values.
module pipe_entry_reg
    import pipe_stage_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          CTRL_W   = 3,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [31:0]         new_pc,
    input  logic [CTRL_W-1:0]   new_ctrl,
    input  logic [2*DATA_W-1:0] new_data,
    input  logic [4:0]          new_wraddr,
    output logic [31:0]         pc,
    output logic [CTRL_W-1:0]   ctrl,
    output logic [2*DATA_W-1:0] data,
    output logic [4:0]          wraddr
);

    // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
    // and the async clear is safe here because the slot is a handful of flops,
    // not a RAM that would lose its inference if given a reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc     <= RESET_PC;
            ctrl   <= '0;
            data   <= '0;
            wraddr <= '0;
        end else if (load) begin
            pc     <= new_pc;
            ctrl   <= new_ctrl;
            data   <= new_data;
            wraddr <= new_wraddr;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Valid/ready pipeline register between EX and WB: two-entry skid buffer with
// registered in_ready (SKID=1) or a single register with combinational in_ready.
module pipe_stage
    import pipe_stage_pkg::*;
#(
    parameter int          DATA_W   = 32,
    parameter int          CTRL_W   = 3,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          SKID     = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         in_pc,
    input  logic [CTRL_W-1:0]   in_ctrl,
    input  logic [2*DATA_W-1:0] in_data,
    input  logic [4:0]          in_wraddr,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         out_pc,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [2*DATA_W-1:0] out_data,
    output logic [4:0]          out_wraddr,
    output logic [1:0]          occupancy
);

    state_t state;
    state_t next_state;
    logic   accept;
    logic   pop;
    logic   head_load;
    logic   skid_load;
    logic   from_skid;

    logic [31:0]         head_pc,     skid_pc,     src_pc;
    logic [CTRL_W-1:0]   head_ctrl,   skid_ctrl,   src_ctrl;
    logic [2*DATA_W-1:0] head_data,   skid_data,   src_data;
    logic [4:0]          head_wraddr, skid_wraddr, src_wraddr;

    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        head_load  = 1'b0;
        skid_load  = 1'b0;
        if (flush) begin
            next_state = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        next_state = ST_ONE;
                        head_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        head_load = 1'b1;
                    end else if (accept) begin
                        next_state = ST_FULL;
                        skid_load  = 1'b1;
                    end else if (pop) begin
                        next_state = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        next_state = ST_ONE;
                        head_load  = 1'b1;
                    end
                end
                default: next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic ready_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    ready_q <= 1'b1;
                end else begin
                    ready_q <= (next_state != ST_FULL);
                end
            end
            assign in_ready = ready_q;
        end else begin : g_comb_ready
            assign in_ready = !out_valid || out_ready;
        end
    endgenerate

    // Only a FULL->ONE pop refills the head from the skid slot; otherwise it takes the input.
    assign from_skid  = (state == ST_FULL);
    assign src_pc     = from_skid ? skid_pc     : in_pc;
    assign src_ctrl   = from_skid ? skid_ctrl   : in_ctrl;
    assign src_data   = from_skid ? skid_data   : in_data;
    assign src_wraddr = from_skid ? skid_wraddr : in_wraddr;

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .RESET_PC (RESET_PC)
    ) u_head (
        .clk        (clk),
        .reset      (reset),
        .load       (head_load),
        .new_pc     (src_pc),
        .new_ctrl   (src_ctrl),
        .new_data   (src_data),
        .new_wraddr (src_wraddr),
        .pc         (head_pc),
        .ctrl       (head_ctrl),
        .data       (head_data),
        .wraddr     (head_wraddr)
    );

    pipe_entry_reg #(
        .DATA_W   (DATA_W),
        .CTRL_W   (CTRL_W),
        .RESET_PC (RESET_PC)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .new_pc     (in_pc),
        .new_ctrl   (in_ctrl),
        .new_data   (in_data),
        .new_wraddr (in_wraddr),
        .pc         (skid_pc),
        .ctrl       (skid_ctrl),
        .data       (skid_data),
        .wraddr     (skid_wraddr)
    );

    // A bubble must never present RegWr, so control is masked when nothing is held.
    assign out_ctrl   = out_valid ? head_ctrl : '0;
    assign out_pc     = head_pc;
    assign out_data   = head_data;
    assign out_wraddr = head_wraddr;
    assign occupancy  = state;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: directed vector table on the skid variant, hand-written
// reset/combinational-ready sequences, then random traffic against a queue model.
module tb_pipe_stage;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [2:0]  ctrl;
        logic [63:0] data;
        logic [4:0]  wraddr;
    } entry_t;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic [1:0]  eocc;
        logic        eir;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [2:0]  in_ctrl;
    logic [63:0] in_data;
    logic [4:0]  in_wraddr;
    logic        flush;
    logic        out_ready;

    logic        in_ready1, out_valid1, in_ready0, out_valid0;
    logic [31:0] out_pc1, out_pc0;
    logic [2:0]  out_ctrl1, out_ctrl0;
    logic [63:0] out_data1, out_data0;
    logic [4:0]  out_wraddr1, out_wraddr0;
    logic [1:0]  occ1, occ0;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t   tbl [40];
    int     n_vec = 0;
    entry_t q1 [$];
    entry_t q0 [$];
    entry_t sh1, sh0;

    always #5 clk = ~clk;

    pipe_stage #(.SKID(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data), .in_wraddr(in_wraddr),
        .flush(flush), .out_valid(out_valid1), .out_ready(out_ready),
        .out_pc(out_pc1), .out_ctrl(out_ctrl1), .out_data(out_data1),
        .out_wraddr(out_wraddr1), .occupancy(occ1)
    );

    pipe_stage #(.SKID(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_pc(in_pc), .in_ctrl(in_ctrl), .in_data(in_data), .in_wraddr(in_wraddr),
        .flush(flush), .out_valid(out_valid0), .out_ready(out_ready),
        .out_pc(out_pc0), .out_ctrl(out_ctrl0), .out_data(out_data0),
        .out_wraddr(out_wraddr0), .occupancy(occ0)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [31:0] pc, input logic ordy, input logic fl,
                       input logic ev, input logic [31:0] epc, input logic [1:0] eocc,
                       input logic eir);
        tbl[n_vec] = '{iv, pc, ordy, fl, ev, epc, eocc, eir};
        n_vec++;
    endtask

    // Directed payloads are derived from the pc so data/wraddr can be predicted.
    task automatic drive_pc(input logic iv, input logic [31:0] pc);
        in_valid  = iv;
        in_pc     = pc;
        in_ctrl   = 3'b101;
        in_data   = {~pc, pc};
        in_wraddr = pc[6:2];
    endtask

    task automatic check_dut(input string tag, input logic valid, input logic ready,
                             input logic [1:0] occ, input logic [31:0] pc, input logic [2:0] ctrl,
                             input logic [63:0] data, input logic [4:0] wa, input int size,
                             input logic exp_ready, input entry_t shadow);
        check({tag, "_valid"}, valid, size > 0);
        check({tag, "_occ"}, occ, size);
        check({tag, "_ready"}, ready, exp_ready);
        check({tag, "_pc"}, pc, shadow.pc);
        check({tag, "_ctrl"}, ctrl, (size > 0) ? shadow.ctrl : 3'b000);
        check({tag, "_data"}, data, shadow.data);
        check({tag, "_wraddr"}, wa, shadow.wraddr);
    endtask

    initial begin
        entry_t rst_e;
        rst_e = '{RST_PC, 3'b000, 64'h0, 5'h0};

        // Table: {in_valid, in_pc, out_ready, flush, exp valid, exp pc, exp occ, exp in_ready}
        add(1, 32'h8000_0004, 1, 0, 0, RST_PC,        0, 1);
        add(0, 32'h0,         0, 0, 1, 32'h8000_0004, 1, 1);
        add(0, 32'h0,         1, 0, 1, 32'h8000_0004, 1, 1);
        add(1, 32'h100,       0, 0, 0, 32'h8000_0004, 0, 1);
        add(1, 32'h104,       0, 0, 1, 32'h100,       1, 1);
        add(1, 32'h108,       0, 0, 1, 32'h100,       2, 0);
        add(1, 32'h108,       0, 0, 1, 32'h100,       2, 0);
        add(1, 32'h108,       1, 0, 1, 32'h100,       2, 0);
        add(1, 32'h108,       1, 0, 1, 32'h104,       1, 1);
        add(0, 32'h0,         1, 0, 1, 32'h108,       1, 1);
        add(0, 32'h0,         1, 0, 0, 32'h108,       0, 1);
        for (int k = 0; k < 8; k++)
            add(1, 32'h200 + 32'(4 * k), 1, 0, k > 0,
                (k == 0) ? 32'h108 : 32'h200 + 32'(4 * (k - 1)), (k > 0) ? 2'd1 : 2'd0, 1);
        add(0, 32'h0,         1, 0, 1, 32'h21C,       1, 1);
        add(0, 32'h0,         1, 0, 0, 32'h21C,       0, 1);
        add(1, 32'h300,       0, 0, 0, 32'h21C,       0, 1);
        add(1, 32'h304,       0, 0, 1, 32'h300,       1, 1);
        add(1, 32'h308,       1, 1, 1, 32'h300,       2, 0);
        add(0, 32'h0,         1, 0, 0, 32'h300,       0, 1);
        add(1, 32'h400,       0, 0, 0, 32'h300,       0, 1);
        add(1, 32'h404,       1, 1, 1, 32'h400,       1, 1);
        add(0, 32'h0,         0, 0, 0, 32'h400,       0, 1);
        add(0, 32'h0,         0, 1, 0, 32'h400,       0, 1);
        add(1, 32'h500,       0, 0, 0, 32'h400,       0, 1);
        add(1, 32'h504,       0, 0, 1, 32'h500,       1, 1);
        add(0, 32'h0,         0, 0, 1, 32'h500,       2, 0);

        reset = 1'b1;
        drive_pc(0, 32'h0);
        flush     = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  out_valid1, 0);
        check("rst_ready",  in_ready1,  1);
        check("rst_occ",    occ1,       0);
        check("rst_pc",     out_pc1,    RST_PC);
        check("rst_ctrl",   out_ctrl1,  0);
        check("rst_data",   out_data1,  0);
        check("rst_wraddr", out_wraddr1, 0);
        check("rst_occ_s0", occ0,       0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < n_vec; i++) begin
            drive_pc(tbl[i].iv, tbl[i].pc);
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            @(negedge clk);
            check($sformatf("vec%0d_valid", i), out_valid1, tbl[i].ev);
            check($sformatf("vec%0d_pc", i),    out_pc1,    tbl[i].epc);
            check($sformatf("vec%0d_occ", i),   occ1,       tbl[i].eocc);
            check($sformatf("vec%0d_ready", i), in_ready1,  tbl[i].eir);
            check($sformatf("vec%0d_ctrl", i),  out_ctrl1,  tbl[i].ev ? 3'b101 : 3'b000);
            if (tbl[i].ev) begin
                check($sformatf("vec%0d_data", i), out_data1, {~tbl[i].epc, tbl[i].epc});
                check($sformatf("vec%0d_wraddr", i), out_wraddr1, tbl[i].epc[6:2]);
            end
            @(posedge clk); #1;
        end

        // Stage is FULL here; reset must clear it without waiting for an edge.
        drive_pc(0, 32'h0);
        flush = 1'b0;
        #2 reset = 1'b1;
        #1;
        check("async_rst_valid", out_valid1, 0);
        check("async_rst_pc",    out_pc1,    RST_PC);
        check("async_rst_occ",   occ1,       0);
        check("async_rst_ctrl",  out_ctrl1,  0);
        check("async_rst_ready", in_ready1,  1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single-register variant: occupancy capped at 1, in_ready follows out_ready.
        drive_pc(1, 32'h600);
        out_ready = 1'b0;
        #1 check("s0_ready_empty", in_ready0, 1);
        @(posedge clk); #1;
        drive_pc(1, 32'h604);
        #1;
        check("s0_ready_blocked", in_ready0, 0);
        check("s0_occ_held",      occ0,      1);
        check("s0_pc_held",       out_pc0,   32'h600);
        out_ready = 1'b1;
        #1 check("s0_ready_comb", in_ready0, 1);
        @(posedge clk); #1;
        for (int k = 0; k < 8; k++) begin
            drive_pc(1, 32'h700 + 32'(4 * k));
            #1;
            check($sformatf("s0_beat%0d_occ", k), occ0, 1);
            check($sformatf("s0_beat%0d_pc", k), out_pc0,
                  (k == 0) ? 32'h604 : 32'h700 + 32'(4 * (k - 1)));
            @(posedge clk); #1;
        end
        drive_pc(0, 32'h0);
        #1 check("s0_last_pc", out_pc0, 32'h71C);
        @(posedge clk); #1;
        check("s0_drained", out_valid0, 0);

        // Random traffic against a queue model of each variant.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        q1.delete();
        q0.delete();
        sh1 = rst_e;
        sh0 = rst_e;
        for (int c = 0; c < 500; c++) begin
            logic r1, r0, pop1, pop0;
            entry_t e;
            in_valid  = ($urandom_range(0, 3) != 0);
            in_pc     = $urandom;
            in_ctrl   = 3'($urandom);
            in_data   = {$urandom, $urandom};
            in_wraddr = 5'($urandom);
            flush     = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            r1 = (q1.size() < 2);
            r0 = (q0.size() == 0) || out_ready;
            @(negedge clk);
            check_dut("rnd_s1", out_valid1, in_ready1, occ1, out_pc1, out_ctrl1, out_data1,
                      out_wraddr1, q1.size(), r1, sh1);
            check_dut("rnd_s0", out_valid0, in_ready0, occ0, out_pc0, out_ctrl0, out_data0,
                      out_wraddr0, q0.size(), r0, sh0);
            e = '{in_pc, in_ctrl, in_data, in_wraddr};
            pop1 = (q1.size() > 0) && out_ready;
            pop0 = (q0.size() > 0) && out_ready;
            @(posedge clk);
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (pop1) void'(q1.pop_front());
                if (in_valid && r1) q1.push_back(e);
                if (pop0) void'(q0.pop_front());
                if (in_valid && r0) q0.push_back(e);
            end
            if (q1.size() > 0) sh1 = q1[0];
            if (q0.size() > 0) sh0 = q0[0];
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of each data payload field (ALU result, read data).
REQ-002 Parameter CTRL_W, default 3, width of the control bundle (MemtoReg[1:0], RegWr).
REQ-003 Parameter RESET_PC, default 32'h8000_0000, value driven on out_pc after reset.
REQ-004 Parameter SKID, default 1: 1 gives a two-entry skid buffer with registered in_ready; 0 gives a single register with combinational in_ready.
REQ-005 Port: clk  input  1  single clock, rising-edge.
REQ-006 Port: reset  input  1  reset, asynchronous, active-high; one clock, no other clock domain.
REQ-007 Port: in_valid  input  1  upstream holds a valid instruction.
REQ-008 Port: in_ready  output  1  stage accepts this cycle.
REQ-009 Port: in_pc  input  32  instruction PC.
REQ-010 Port: in_ctrl  input  CTRL_W  control bundle.
REQ-011 Port: in_data  input  2*DATA_W  {rd_data, alu_out}.
REQ-012 Port: in_wraddr  input  5  destination register.
REQ-013 Port: flush  input  1  discard all held entries.
REQ-014 Port: out_valid / out_ready  output / input  1 each  downstream handshake.
REQ-015 Port: out_pc, out_ctrl, out_data, out_wraddr  output  32 / CTRL_W / 2*DATA_W / 5  head-entry payload.
REQ-016 Port: occupancy  output  2  entries currently held (0..2).

Function
REQ-017 Accept iff in_valid && in_ready at a rising edge; pop iff out_valid && out_ready.
REQ-018 Latency: an entry accepted into an empty stage appears on out_* with out_valid=1 in the following cycle.
REQ-019 Order is strictly FIFO; no entry is dropped or duplicated except by flush.
REQ-020 SKID=1 states: EMPTY (occ 0), ONE (occ 1), FULL (occ 2); in_ready is a register output equal to (state != FULL).
REQ-021 EMPTY: accept -> ONE; otherwise stay.
REQ-022 ONE: accept and pop -> ONE (head replaced by new entry); accept only -> FULL (new entry into skid); pop only -> EMPTY.
REQ-023 FULL: pop -> ONE (skid moves to head, same edge); no accept is possible.
REQ-024 SKID=0: single register; in_ready = !out_valid || out_ready (combinational); occupancy is 0 or 1.
REQ-025 out_ctrl, when out_valid=0, reads as all-zero so that RegWr is never asserted by a bubble; other out_* fields retain their last value.
REQ-026 flush (synchronous) forces EMPTY at the next edge and overrides a simultaneous accept and pop; the input entry in that cycle is discarded; in_ready=1 in the following cycle.
REQ-027 flush while EMPTY has no effect apart from holding EMPTY.

Reset
REQ-028 While reset=1: state EMPTY, out_valid=0, in_ready=1 (SKID=1), occupancy=0, out_pc=RESET_PC, out_ctrl=0, out_data=0, out_wraddr=0, skid register cleared.
REQ-029 Reset asserted mid-operation discards all held entries immediately, without waiting for a clock edge.
REQ-030 The first accept is possible at the first rising edge after reset deasserts.

Structure
REQ-031 A shared package holds the state encoding (EMPTY/ONE/FULL) and the RESET_PC default constant.
REQ-032 Payload storage is one sub-module, pipe_entry_reg (load enable, async clear to reset values), instantiated as head and skid.

Verification
REQ-033 Reset, then single accept pc=0x8000_0004, alu=0x11 -> next cycle out_valid=1, out_pc=0x8000_0004, occupancy=1.
REQ-034 out_ready=0, three consecutive in_valid beats A, B, C -> A and B held (occupancy=2), in_ready=0 on C's cycle, C held by upstream; out_ready=1 -> A, B, C emerge in order, one per cycle.
REQ-035 Continuous in_valid=1 and out_ready=1 for 8 beats -> throughput 1 per cycle, occupancy stays 1, no loss.
REQ-036 FULL stage, flush=1 with simultaneous in_valid=1 -> next cycle out_valid=0, occupancy=0, out_ctrl=0, in_ready=1; the flushed input never appears.
REQ-037 Assert reset mid-stream while FULL -> out_valid=0 and out_pc=0x8000_0000 before the next edge.
REQ-038 Repeat REQ-034 and REQ-035 with SKID=0 -> occupancy never exceeds 1, in_ready tracks out_ready combinationally.
